// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - RV32I opcode/funct encodings and ALU op/sel enums for the ID stage
package id_stage_pipe_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [4:0] {
        ALU_NOP_OP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
        ALU_SB, ALU_SH, ALU_SW, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
        ALU_BGEU, ALU_JAL, ALU_JALR
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_NOP_SEL, SEL_ARITH, SEL_LOGIC, SEL_SHIFT, SEL_MEM, SEL_BRANCH, SEL_JUMP
    } alu_sel_e;

    typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} src1_e;

    function automatic logic is_load(alu_op_e op);
        return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    function automatic alu_sel_e sel_of(alu_op_e op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU:                   return SEL_ARITH;
            ALU_XOR, ALU_OR, ALU_AND:                              return SEL_LOGIC;
            ALU_SLL, ALU_SRL, ALU_SRA:                             return SEL_SHIFT;
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW:                                return SEL_MEM;
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: return SEL_BRANCH;
            ALU_JAL, ALU_JALR:                                     return SEL_JUMP;
            default:                                               return ALU_NOP_SEL;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - IF/ID input handshake and ID/EX register bundle
interface id_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    import id_stage_pipe_pkg::*;

    logic              valid_IFID_i;
    logic              ready_IFID_o;
    logic [31:0]       inst_IFID_i;
    logic [XLEN-1:0]   pc_IFID_i;
    logic              flush_i;
    logic              valid_IDEX_o;
    logic              ready_IDEX_i;
    alu_op_e           aluop_IDEX_o;
    alu_sel_e          alusel_IDEX_o;
    logic [XLEN-1:0]   regdata1_IDEX_o;
    logic [XLEN-1:0]   regdata2_IDEX_o;
    logic [XLEN-1:0]   storedata_IDEX_o;
    logic [XLEN-1:0]   pc_IDEX_o;
    logic              wreg_IDEX_o;
    logic [REG_AW-1:0] waddr_IDEX_o;
    logic              illegal_IDEX_o;

    modport slave (
        input  valid_IFID_i, inst_IFID_i, pc_IFID_i, flush_i, ready_IDEX_i,
        output ready_IFID_o, valid_IDEX_o, aluop_IDEX_o, alusel_IDEX_o, regdata1_IDEX_o,
               regdata2_IDEX_o, storedata_IDEX_o, pc_IDEX_o, wreg_IDEX_o, waddr_IDEX_o,
               illegal_IDEX_o
    );

    modport master (
        output valid_IFID_i, inst_IFID_i, pc_IFID_i, flush_i, ready_IDEX_i,
        input  ready_IFID_o, valid_IDEX_o, aluop_IDEX_o, alusel_IDEX_o, regdata1_IDEX_o,
               regdata2_IDEX_o, storedata_IDEX_o, pc_IDEX_o, wreg_IDEX_o, waddr_IDEX_o,
               illegal_IDEX_o
    );

endinterface

// File: rtl/id_stage_pipe_imm_gen.sv
// rtl/id_stage_pipe_imm_gen.sv - combinational RV32I immediate extraction, sign-extended to XLEN
module id_stage_pipe_imm_gen
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:                      imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:             imm32 = {inst[31:12], 12'b0};
            OPC_JAL: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:                        imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RV32I decode with operand forwarding, load-use stall and ID/EX register
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int FWD_PORTS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    id_stage_pipe_if.slave              pipe,
    output logic                        re1_REGFILE_o,
    output logic [REG_AW-1:0]           raddr1_REGFILE_o,
    input  logic [XLEN-1:0]             rdata1_REGFILE_i,
    output logic                        re2_REGFILE_o,
    output logic [REG_AW-1:0]           raddr2_REGFILE_o,
    input  logic [XLEN-1:0]             rdata2_REGFILE_i,
    input  logic [FWD_PORTS-1:0]        fwd_we_i,
    input  logic [FWD_PORTS*REG_AW-1:0] fwd_addr_i,
    input  logic [FWD_PORTS*XLEN-1:0]   fwd_data_i
);

    logic [31:0]       inst;
    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [XLEN-1:0]   imm, rs1_val, rs2_val, op1, op2;

    alu_op_e d_op;
    src1_e   d_src1;
    logic    d_use1, d_use2, d_op2_imm, d_store, d_writes, d_illegal;
    logic    hazard, fire, update;

    alu_op_e           nxt_op;
    logic              nxt_valid, nxt_wreg, nxt_ill;
    logic [XLEN-1:0]   nxt_r1, nxt_r2, nxt_sd, nxt_pc;
    logic [REG_AW-1:0] nxt_waddr;

    assign inst   = pipe.inst_IFID_i;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = REG_AW'(inst[11:7]);
    assign rs1    = REG_AW'(inst[19:15]);
    assign rs2    = REG_AW'(inst[24:20]);

    id_stage_pipe_imm_gen #(.XLEN(XLEN)) u_imm_gen (.inst(inst), .imm(imm));

    always_comb begin
        d_op      = ALU_NOP_OP;
        d_src1    = SRC1_RS1;
        d_use1    = 1'b0;
        d_use2    = 1'b0;
        d_op2_imm = 1'b1;
        d_store   = 1'b0;
        d_writes  = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                d_use1   = 1'b1;
                d_writes = 1'b1;
                case (funct3)
                    F3_ADD:  d_op = ALU_ADD;
                    F3_SLT:  d_op = ALU_SLT;
                    F3_SLTU: d_op = ALU_SLTU;
                    F3_XOR:  d_op = ALU_XOR;
                    F3_OR:   d_op = ALU_OR;
                    F3_AND:  d_op = ALU_AND;
                    F3_SLL:  if (funct7 == F7_BASE) d_op = ALU_SLL; else d_illegal = 1'b1;
                    default: begin
                        if (funct7 == F7_BASE)     d_op = ALU_SRL;
                        else if (funct7 == F7_ALT) d_op = ALU_SRA;
                        else                       d_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                d_use1    = 1'b1;
                d_use2    = 1'b1;
                d_op2_imm = 1'b0;
                d_writes  = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}:  d_op = ALU_ADD;
                    {F7_ALT,  F3_ADD}:  d_op = ALU_SUB;
                    {F7_BASE, F3_SLL}:  d_op = ALU_SLL;
                    {F7_BASE, F3_SLT}:  d_op = ALU_SLT;
                    {F7_BASE, F3_SLTU}: d_op = ALU_SLTU;
                    {F7_BASE, F3_XOR}:  d_op = ALU_XOR;
                    {F7_BASE, F3_SR}:   d_op = ALU_SRL;
                    {F7_ALT,  F3_SR}:   d_op = ALU_SRA;
                    {F7_BASE, F3_OR}:   d_op = ALU_OR;
                    {F7_BASE, F3_AND}:  d_op = ALU_AND;
                    default:            d_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                d_op     = ALU_ADD;
                d_src1   = SRC1_ZERO;
                d_writes = 1'b1;
            end
            OPC_AUIPC: begin
                d_op     = ALU_ADD;
                d_src1   = SRC1_PC;
                d_writes = 1'b1;
            end
            OPC_LOAD: begin
                d_use1   = 1'b1;
                d_writes = 1'b1;
                case (funct3)
                    3'b000:  d_op = ALU_LB;
                    3'b001:  d_op = ALU_LH;
                    3'b010:  d_op = ALU_LW;
                    3'b100:  d_op = ALU_LBU;
                    3'b101:  d_op = ALU_LHU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_use1  = 1'b1;
                d_use2  = 1'b1;
                d_store = 1'b1;
                case (funct3)
                    3'b000:  d_op = ALU_SB;
                    3'b001:  d_op = ALU_SH;
                    3'b010:  d_op = ALU_SW;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                // rs2 travels on the store-data lane so operand 2 can carry the branch offset
                d_use1  = 1'b1;
                d_use2  = 1'b1;
                d_store = 1'b1;
                case (funct3)
                    3'b000:  d_op = ALU_BEQ;
                    3'b001:  d_op = ALU_BNE;
                    3'b100:  d_op = ALU_BLT;
                    3'b101:  d_op = ALU_BGE;
                    3'b110:  d_op = ALU_BLTU;
                    3'b111:  d_op = ALU_BGEU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                d_op     = ALU_JAL;
                d_src1   = SRC1_PC;
                d_writes = 1'b1;
            end
            OPC_JALR: begin
                d_use1   = 1'b1;
                d_writes = 1'b1;
                if (funct3 == 3'b000) d_op = ALU_JALR; else d_illegal = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_op     = ALU_NOP_OP;
            d_src1   = SRC1_ZERO;
            d_use1   = 1'b0;
            d_use2   = 1'b0;
            d_store  = 1'b0;
            d_writes = 1'b0;
        end
    end

    // Descending scan so the lowest (youngest) matching port is applied last and wins.
    always_comb begin
        rs1_val = rdata1_REGFILE_i;
        rs2_val = rdata2_REGFILE_i;
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (fwd_we_i[i] && fwd_addr_i[i*REG_AW +: REG_AW] == rs1) rs1_val = fwd_data_i[i*XLEN +: XLEN];
            if (fwd_we_i[i] && fwd_addr_i[i*REG_AW +: REG_AW] == rs2) rs2_val = fwd_data_i[i*XLEN +: XLEN];
        end
        if (rs1 == '0) rs1_val = '0;
        if (rs2 == '0) rs2_val = '0;
    end

    always_comb begin
        case (d_src1)
            SRC1_PC:   op1 = pipe.pc_IFID_i;
            SRC1_ZERO: op1 = '0;
            default:   op1 = rs1_val;
        endcase
        op2 = d_op2_imm ? imm : rs2_val;
        if (d_illegal) op2 = '0;
    end

    assign hazard = pipe.valid_IDEX_o && is_load(pipe.aluop_IDEX_o) && (pipe.waddr_IDEX_o != '0)
                    && ((d_use1 && rs1 == pipe.waddr_IDEX_o) || (d_use2 && rs2 == pipe.waddr_IDEX_o));

    assign pipe.ready_IFID_o = (!pipe.valid_IDEX_o || pipe.ready_IDEX_i) && !hazard && !pipe.flush_i;
    assign fire              = pipe.valid_IFID_i && pipe.ready_IFID_o;
    assign update            = pipe.flush_i || !pipe.valid_IDEX_o || pipe.ready_IDEX_i;

    assign re1_REGFILE_o    = !rst && pipe.valid_IFID_i && d_use1;
    assign re2_REGFILE_o    = !rst && pipe.valid_IFID_i && d_use2;
    assign raddr1_REGFILE_o = rs1;
    assign raddr2_REGFILE_o = rs2;

    always_comb begin
        nxt_valid = 1'b0;
        nxt_op    = ALU_NOP_OP;
        nxt_r1    = '0;
        nxt_r2    = '0;
        nxt_sd    = '0;
        nxt_pc    = '0;
        nxt_wreg  = 1'b0;
        nxt_waddr = '0;
        nxt_ill   = 1'b0;
        if (fire) begin
            nxt_valid = 1'b1;
            nxt_op    = d_op;
            nxt_r1    = op1;
            nxt_r2    = op2;
            nxt_sd    = d_store ? rs2_val : '0;
            nxt_pc    = pipe.pc_IFID_i;
            nxt_wreg  = d_writes && (rd != '0);
            nxt_waddr = nxt_wreg ? rd : '0;
            nxt_ill   = d_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe.valid_IDEX_o     <= 1'b0;
            pipe.aluop_IDEX_o     <= ALU_NOP_OP;
            pipe.alusel_IDEX_o    <= ALU_NOP_SEL;
            pipe.regdata1_IDEX_o  <= '0;
            pipe.regdata2_IDEX_o  <= '0;
            pipe.storedata_IDEX_o <= '0;
            pipe.pc_IDEX_o        <= '0;
            pipe.wreg_IDEX_o      <= 1'b0;
            pipe.waddr_IDEX_o     <= '0;
            pipe.illegal_IDEX_o   <= 1'b0;
        end else if (update) begin
            pipe.valid_IDEX_o     <= nxt_valid;
            pipe.aluop_IDEX_o     <= nxt_op;
            pipe.alusel_IDEX_o    <= sel_of(nxt_op);
            pipe.regdata1_IDEX_o  <= nxt_r1;
            pipe.regdata2_IDEX_o  <= nxt_r2;
            pipe.storedata_IDEX_o <= nxt_sd;
            pipe.pc_IDEX_o        <= nxt_pc;
            pipe.wreg_IDEX_o      <= nxt_wreg;
            pipe.waddr_IDEX_o     <= nxt_waddr;
            pipe.illegal_IDEX_o   <= nxt_ill;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed bench for id_stage_pipe
`timescale 1ns/1ps
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;
    localparam int FWD_PORTS = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        re1, re2;
    logic [REG_AW-1:0]           raddr1, raddr2;
    logic [XLEN-1:0]             rdata1, rdata2;
    logic [FWD_PORTS-1:0]        fwd_we;
    logic [FWD_PORTS*REG_AW-1:0] fwd_addr;
    logic [FWD_PORTS*XLEN-1:0]   fwd_data;
    int total = 0;
    int bad   = 0;

    id_stage_pipe_if #(.XLEN(XLEN), .REG_AW(REG_AW)) pipe ();

    id_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipe             (pipe),
        .re1_REGFILE_o    (re1),
        .raddr1_REGFILE_o (raddr1),
        .rdata1_REGFILE_i (rdata1),
        .re2_REGFILE_o    (re2),
        .raddr2_REGFILE_o (raddr2),
        .rdata2_REGFILE_i (rdata2),
        .fwd_we_i         (fwd_we),
        .fwd_addr_i       (fwd_addr),
        .fwd_data_i       (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst, pc, rd1, rd2, r1, r2, sd, op, wreg, waddr, ill;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h00500093, 32'h100, 32'h55, 32'h66, 32'h0, 32'h5, 32'h0, 32'(ALU_ADD), 1, 1, 0};
        vecs[1] = '{32'hFE20AE23, 32'h104, 32'h1000, 32'hDEADBEEF, 32'h1000, 32'hFFFFFFFC, 32'hDEADBEEF, 32'(ALU_SW), 0, 0, 0};
        vecs[2] = '{32'h008000EF, 32'h300, 32'h55, 32'h66, 32'h300, 32'h8, 32'h0, 32'(ALU_JAL), 1, 1, 0};
        vecs[3] = '{32'hFE208CE3, 32'h400, 32'h10, 32'h20, 32'h10, 32'hFFFFFFF8, 32'h20, 32'(ALU_BEQ), 0, 0, 0};
        vecs[4] = '{32'h123452B7, 32'h500, 32'h55, 32'h66, 32'h0, 32'h12345000, 32'h0, 32'(ALU_ADD), 1, 5, 0};
        vecs[5] = '{32'h00001117, 32'h200, 32'h55, 32'h66, 32'h200, 32'h1000, 32'h0, 32'(ALU_ADD), 1, 2, 0};
        vecs[6] = '{32'h0000007F, 32'h600, 32'h55, 32'h66, 32'h0, 32'h0, 32'h0, 32'(ALU_NOP_OP), 0, 0, 1};
        vecs[7] = '{32'h40001033, 32'h604, 32'h55, 32'h66, 32'h0, 32'h0, 32'h0, 32'(ALU_NOP_OP), 0, 0, 1};
        vecs[8] = '{32'h402081B3, 32'h608, 32'h7, 32'h3, 32'h7, 32'h3, 32'h0, 32'(ALU_SUB), 1, 3, 0};
        vecs[9] = '{32'h4032D293, 32'h60C, 32'h80, 32'h66, 32'h80, 32'h403, 32'h0, 32'(ALU_SRA), 1, 5, 0};

        rst = 1'b1;
        pipe.valid_IFID_i = 1'b0;
        pipe.inst_IFID_i  = '0;
        pipe.pc_IFID_i    = '0;
        pipe.flush_i      = 1'b0;
        pipe.ready_IDEX_i = 1'b0;
        rdata1 = '0; rdata2 = '0; fwd_we = '0; fwd_addr = '0; fwd_data = '0;
        step();
        step();

        // reset state, with a live instruction presented
        pipe.valid_IFID_i = 1'b1;
        pipe.inst_IFID_i  = 32'h00500093;
        #1;
        chk("rst_valid", 32'(pipe.valid_IDEX_o), 0);
        chk("rst_aluop", 32'(pipe.aluop_IDEX_o), 32'(ALU_NOP_OP));
        chk("rst_alusel", 32'(pipe.alusel_IDEX_o), 32'(ALU_NOP_SEL));
        chk("rst_wreg", 32'(pipe.wreg_IDEX_o), 0);
        chk("rst_re1", 32'(re1), 0);
        rst = 1'b0;
        pipe.ready_IDEX_i = 1'b1;
        #1;
        chk("addi_re1", 32'(re1), 1);
        chk("addi_re2", 32'(re2), 0);
        chk("addi_ready", 32'(pipe.ready_IFID_o), 1);

        // decode table, EX always ready
        for (int i = 0; i < 10; i++) begin
            pipe.inst_IFID_i = vecs[i].inst;
            pipe.pc_IFID_i   = vecs[i].pc;
            rdata1 = vecs[i].rd1;
            rdata2 = vecs[i].rd2;
            step();
            chk($sformatf("v%0d_valid", i), 32'(pipe.valid_IDEX_o), 1);
            chk($sformatf("v%0d_aluop", i), 32'(pipe.aluop_IDEX_o), vecs[i].op);
            chk($sformatf("v%0d_r1", i), pipe.regdata1_IDEX_o, vecs[i].r1);
            chk($sformatf("v%0d_r2", i), pipe.regdata2_IDEX_o, vecs[i].r2);
            chk($sformatf("v%0d_sd", i), pipe.storedata_IDEX_o, vecs[i].sd);
            chk($sformatf("v%0d_wreg", i), 32'(pipe.wreg_IDEX_o), vecs[i].wreg);
            chk($sformatf("v%0d_waddr", i), 32'(pipe.waddr_IDEX_o), vecs[i].waddr);
            chk($sformatf("v%0d_ill", i), 32'(pipe.illegal_IDEX_o), vecs[i].ill);
        end

        // load-use: lw x3,0(x1) then add x4,x3,x3
        pipe.inst_IFID_i = 32'h0000A183;
        pipe.pc_IFID_i   = 32'h700;
        rdata1 = 32'h1000;
        step();
        chk("lw_aluop", 32'(pipe.aluop_IDEX_o), 32'(ALU_LW));
        chk("lw_waddr", 32'(pipe.waddr_IDEX_o), 3);
        pipe.inst_IFID_i = 32'h00318233;
        pipe.pc_IFID_i   = 32'h704;
        #1;
        chk("hz_ready", 32'(pipe.ready_IFID_o), 0);
        step();
        chk("hz_bubble_valid", 32'(pipe.valid_IDEX_o), 0);
        chk("hz_bubble_wreg", 32'(pipe.wreg_IDEX_o), 0);
        chk("hz_ready_after", 32'(pipe.ready_IFID_o), 1);
        step();
        chk("hz_add_valid", 32'(pipe.valid_IDEX_o), 1);
        chk("hz_add_aluop", 32'(pipe.aluop_IDEX_o), 32'(ALU_ADD));
        chk("hz_add_waddr", 32'(pipe.waddr_IDEX_o), 4);
        chk("hz_add_pc", pipe.pc_IDEX_o, 32'h704);

        // forwarding priority: add x6,x5,x0
        fwd_we   = 2'b11;
        fwd_addr = {5'd5, 5'd5};
        fwd_data = {32'h22, 32'h11};
        rdata1 = 32'h99;
        rdata2 = 32'h77;
        pipe.inst_IFID_i = 32'h00028333;
        step();
        chk("fwd_port0", pipe.regdata1_IDEX_o, 32'h11);
        chk("fwd_rs2_x0", pipe.regdata2_IDEX_o, 32'h0);
        fwd_we = 2'b10;
        step();
        chk("fwd_port1", pipe.regdata1_IDEX_o, 32'h22);
        fwd_we = 2'b00;
        step();
        chk("fwd_none", pipe.regdata1_IDEX_o, 32'h99);
        fwd_we   = 2'b11;
        fwd_addr = '0;
        pipe.inst_IFID_i = 32'h00000333;
        step();
        chk("fwd_x0", pipe.regdata1_IDEX_o, 32'h0);
        fwd_we = 2'b00;

        // hold with EX stalled, then flush
        pipe.inst_IFID_i = 32'hFFF00393;
        pipe.pc_IFID_i   = 32'h800;
        step();
        chk("hold_load_r2", pipe.regdata2_IDEX_o, 32'hFFFFFFFF);
        pipe.ready_IDEX_i = 1'b0;
        pipe.inst_IFID_i  = 32'h00500093;
        pipe.pc_IFID_i    = 32'h900;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hold%0d_valid", k), 32'(pipe.valid_IDEX_o), 1);
            chk($sformatf("hold%0d_r2", k), pipe.regdata2_IDEX_o, 32'hFFFFFFFF);
            chk($sformatf("hold%0d_waddr", k), 32'(pipe.waddr_IDEX_o), 7);
            chk($sformatf("hold%0d_ready", k), 32'(pipe.ready_IFID_o), 0);
        end
        pipe.flush_i = 1'b1;
        step();
        chk("flush_valid", 32'(pipe.valid_IDEX_o), 0);
        chk("flush_wreg", 32'(pipe.wreg_IDEX_o), 0);
        pipe.flush_i = 1'b0;
        step();
        chk("refill_valid", 32'(pipe.valid_IDEX_o), 1);
        chk("refill_pc", pipe.pc_IDEX_o, 32'h900);

        // asynchronous reset while held
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(pipe.valid_IDEX_o), 0);
        chk("arst_pc", pipe.pc_IDEX_o, 32'h0);
        chk("arst_r2", pipe.regdata2_IDEX_o, 32'h0);
        chk("arst_wreg", 32'(pipe.wreg_IDEX_o), 0);
        chk("arst_re1", 32'(re1), 0);
        step();
        rst = 1'b0;
        #1;
        chk("no_replay_valid", 32'(pipe.valid_IDEX_o), 0);

        // illegal opcode after reset
        pipe.ready_IDEX_i = 1'b1;
        pipe.inst_IFID_i  = 32'h0000007F;
        step();
        chk("ill_valid", 32'(pipe.valid_IDEX_o), 1);
        chk("ill_flag", 32'(pipe.illegal_IDEX_o), 1);
        chk("ill_wreg", 32'(pipe.wreg_IDEX_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
